// File: rtl/jtag_master.sv
// JTAG scan engine: sequences TAP reset, IR/DR scans and idle clocks on TCK/TMS/TDI,
// shifting data MSB-first and returning captured TDO bits through a response handshake.
module jtag_master #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [5:0]            cmd_length,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  jtag_tck,
  output logic                  jtag_tms,
  output logic                  jtag_tdi,
  input  logic                  jtag_tdo
);

  typedef enum logic [2:0] {IDLE, HEADER, SHIFT, TRAILER, RESP} state_t;

  state_t                state, state_n;
  logic [1:0]            typ, typ_n;
  logic [5:0]            len, len_n, idx, idx_n, hdr_len, eff_len;
  logic [DATA_WIDTH-1:0] sh, sh_n, rsp, rsp_n;
  logic [15:0]           cnt, cnt_n;
  logic                  ph, ph_n, cap, cap_n;
  logic                  tck_n, tms_n, tdi_n, hdr_tms, is_scan;

  always_comb begin
    if (cmd_length == 6'd0)
      eff_len = 6'd1;
    else if (int'(cmd_length) > DATA_WIDTH)
      eff_len = 6'(DATA_WIDTH);
    else
      eff_len = cmd_length;
  end

  // Header covers the whole TMS walk for reset and idle commands, so they never shift.
  always_comb begin
    hdr_len = len;
    hdr_tms = 1'b0;
    case (typ)
      2'd0: begin hdr_len = 6'd6; hdr_tms = (idx < 6'd5);  end
      2'd1: begin hdr_len = 6'd4; hdr_tms = (idx < 6'd2);  end
      2'd2: begin hdr_len = 6'd3; hdr_tms = (idx == 6'd0); end
      default: begin hdr_len = len; hdr_tms = 1'b0; end
    endcase
  end

  assign is_scan   = (typ == 2'd1) || (typ == 2'd2);
  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      typ      <= 2'd0;
      len      <= 6'd0;
      idx      <= 6'd0;
      sh       <= '0;
      rsp      <= '0;
      cnt      <= 16'd0;
      ph       <= 1'b0;
      cap      <= 1'b0;
      jtag_tck <= 1'b0;
      jtag_tms <= 1'b0;
      jtag_tdi <= 1'b0;
    end else begin
      state    <= state_n;
      typ      <= typ_n;
      len      <= len_n;
      idx      <= idx_n;
      sh       <= sh_n;
      rsp      <= rsp_n;
      cnt      <= cnt_n;
      ph       <= ph_n;
      cap      <= cap_n;
      jtag_tck <= tck_n;
      jtag_tms <= tms_n;
      jtag_tdi <= tdi_n;
    end
  end

  // ph=1 means the next divider event opens a low phase (emit next bit or finish),
  // ph=0 means it raises TCK and samples TDO for the bit currently on the pins.
  always_comb begin
    state_n = state;
    typ_n   = typ;
    len_n   = len;
    idx_n   = idx;
    sh_n    = sh;
    rsp_n   = rsp;
    cnt_n   = cnt;
    ph_n    = ph;
    cap_n   = cap;
    tck_n   = jtag_tck;
    tms_n   = jtag_tms;
    tdi_n   = jtag_tdi;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n = HEADER;
          typ_n   = cmd_type;
          len_n   = eff_len;
          idx_n   = 6'd0;
          sh_n    = cmd_data << (DATA_WIDTH - int'(eff_len));
          rsp_n   = '0;
          cnt_n   = 16'd0;
          ph_n    = 1'b1;
          cap_n   = 1'b0;
        end
      end
      HEADER, SHIFT, TRAILER: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          cnt_n = 16'(CLK_DIV - 1);
          if (!ph) begin
            ph_n  = 1'b1;
            tck_n = 1'b1;
            if (cap)
              rsp_n = {rsp[DATA_WIDTH-2:0], jtag_tdo};
          end else begin
            ph_n  = 1'b0;
            tck_n = 1'b0;
            tms_n = 1'b0;
            tdi_n = 1'b0;
            cap_n = 1'b0;
            if (state == HEADER) begin
              if (idx == hdr_len) begin
                state_n = RESP;
              end else begin
                tms_n = hdr_tms;
                idx_n = idx + 6'd1;
                if ((idx + 6'd1 == hdr_len) && is_scan) begin
                  state_n = SHIFT;
                  idx_n   = 6'd0;
                end
              end
            end else if (state == SHIFT) begin
              tms_n = (idx == len - 6'd1);
              tdi_n = sh[DATA_WIDTH-1];
              sh_n  = sh << 1;
              cap_n = 1'b1;
              if (idx == len - 6'd1) begin
                state_n = TRAILER;
                idx_n   = 6'd0;
              end else begin
                idx_n = idx + 6'd1;
              end
            end else begin
              if (idx == 6'd2) begin
                state_n = RESP;
              end else begin
                tms_n = (idx == 6'd0);
                idx_n = idx + 6'd1;
              end
            end
          end
        end
      end
      RESP: begin
        if (rsp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtag_master.sv
// Randomized bench for jtag_master: a timing/sequence model predicts every pin and
// handshake output each cycle, plus directed literal checks of the TMS/TDI sequences.
module tb_jtag_master;

  localparam int W = 32;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_type = 2'd0;
  logic [5:0]   cmd_length = 6'd0;
  logic [W-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         busy;
  logic         jtag_tck, jtag_tms, jtag_tdi;
  logic         jtag_tdo = 1'b0;

  jtag_master #(.DATA_WIDTH(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_length(cmd_length), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_tdo(jtag_tdo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Model of the command in flight: per-TCK TMS/TDI/TDO, TCK count and expected response.
  bit         exp_tms[$];
  bit         exp_tdi[$];
  bit         tdo_seq[$];
  int         exp_n, exp_hdr, exp_len;
  logic [W-1:0] exp_rsp;
  bit         active = 0;
  bit         checking = 0;
  int         acc = 0;
  int         rise_cyc = 0;
  logic [W-1:0] last_rsp;

  bit mon_tms[$];
  bit mon_tdi[$];
  always @(posedge jtag_tck) begin
    mon_tms.push_back(jtag_tms);
    mon_tdi.push_back(jtag_tdi);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] packTms(input int from, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], mon_tms[from+i]};
    return r;
  endfunction

  function automatic logic [31:0] packTdi(input int from, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], mon_tdi[from+i]};
    return r;
  endfunction

  task automatic buildModel(input logic [1:0] typ, input logic [5:0] length,
                            input logic [W-1:0] data, input bit use_dev, input logic [31:0] dev_val);
    exp_tms.delete(); exp_tdi.delete(); tdo_seq.delete();
    exp_len = (length == 0) ? 1 : ((int'(length) > W) ? W : int'(length));
    exp_hdr = 0;
    exp_rsp = '0;
    case (typ)
      2'd0: begin
        for (int i = 0; i < 6; i++) begin exp_tms.push_back(i < 5); exp_tdi.push_back(0); end
      end
      2'd3: begin
        for (int i = 0; i < exp_len; i++) begin exp_tms.push_back(0); exp_tdi.push_back(0); end
      end
      default: begin
        if (typ == 2'd1) begin
          exp_tms = '{1, 1, 0, 0};
        end else begin
          exp_tms = '{1, 0, 0};
        end
        exp_hdr = exp_tms.size();
        for (int i = 0; i < exp_hdr; i++) exp_tdi.push_back(0);
        for (int k = 0; k < exp_len; k++) begin
          exp_tms.push_back(k == exp_len - 1);
          exp_tdi.push_back(data[exp_len-1-k]);
        end
        exp_tms.push_back(1); exp_tdi.push_back(0);
        exp_tms.push_back(0); exp_tdi.push_back(0);
      end
    endcase
    exp_n = exp_tms.size();
    for (int i = 0; i < exp_n; i++) tdo_seq.push_back(1'($urandom_range(0, 1)));
    if (typ == 2'd1 || typ == 2'd2) begin
      for (int k = 0; k < exp_len; k++) begin
        if (use_dev) tdo_seq[exp_hdr+k] = dev_val[exp_len-1-k];
        exp_rsp = exp_rsp | (W'(tdo_seq[exp_hdr+k]) << (exp_len - 1 - k));
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] typ, input logic [5:0] length,
                               input logic [W-1:0] data, input bit use_dev,
                               input logic [31:0] dev_val, input int hold, input bit abort);
    buildModel(typ, length, data, use_dev, dev_val);
    mon_tms.delete(); mon_tdi.delete();
    cmd_type = typ; cmd_length = length; cmd_data = data; cmd_valid = 1'b1;
    tick();
    acc = cyc;
    active = 1;
    cmd_valid = 1'b0;
    cmd_type = 2'($urandom); cmd_length = 6'($urandom); cmd_data = $urandom;
    if (abort) begin
      while (cyc < acc + 1 + 2*D*(exp_hdr + 2) + 1) tick();
      rst = 1'b1;
      tick();
      active = 0;
      rst = 1'b0;
      checkOutput("abort_tck", 32'(jtag_tck), 0);
      checkOutput("abort_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("abort_cmd_ready", 32'(cmd_ready), 1);
      checkOutput("abort_rsp_data", rsp_data, 0);
      return;
    end
    while (cyc < acc + 1 + 2*D*exp_n) tick();
    repeat (hold) tick();
    last_rsp = rsp_data;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    active = 0;
  endtask

  // Per-cycle compare against the model; also drives TDO from the model's TCK timeline.
  bit prev_rv = 0;
  always @(negedge clk) begin : compare
    int c, t, b;
    if (checking) begin
      c = cyc;
      if (rsp_valid && !prev_rv) rise_cyc = c;
      prev_rv = rsp_valid;
      if (!active) begin
        checkOutput("idle_cmd_ready", 32'(cmd_ready), 1);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("idle_tck", 32'(jtag_tck), 0);
        checkOutput("idle_tms", 32'(jtag_tms), 0);
        checkOutput("idle_tdi", 32'(jtag_tdi), 0);
        jtag_tdo = 1'b0;
      end else if (c == acc) begin
        checkOutput("acc_cmd_ready", 32'(cmd_ready), 0);
        checkOutput("acc_busy", 32'(busy), 1);
        checkOutput("acc_rsp_data", rsp_data, 0);
        checkOutput("acc_tck", 32'(jtag_tck), 0);
        checkOutput("acc_tms", 32'(jtag_tms), 0);
        jtag_tdo = tdo_seq[0];
      end else begin
        t = c - acc - 1;
        if (t < 2*D*exp_n) begin
          b = t / (2*D);
          checkOutput("run_tck", 32'(jtag_tck), 32'((t % (2*D)) >= D));
          checkOutput("run_tms", 32'(jtag_tms), 32'(exp_tms[b]));
          checkOutput("run_tdi", 32'(jtag_tdi), 32'(exp_tdi[b]));
          checkOutput("run_rsp_valid", 32'(rsp_valid), 0);
          checkOutput("run_cmd_ready", 32'(cmd_ready), 0);
          jtag_tdo = tdo_seq[b];
        end else begin
          checkOutput("resp_valid", 32'(rsp_valid), 1);
          checkOutput("resp_data", rsp_data, exp_rsp);
          checkOutput("resp_tck", 32'(jtag_tck), 0);
          checkOutput("resp_tms", 32'(jtag_tms), 0);
          checkOutput("resp_tdi", 32'(jtag_tdi), 0);
          checkOutput("resp_cmd_ready", 32'(cmd_ready), 0);
          checkOutput("resp_busy", 32'(busy), 1);
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    checking = 1;
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("reset_tck", 32'(jtag_tck), 0);
    rst = 1'b0;
    tick();

    applyStimulus(2'd0, 6'd0, 32'h0, 0, 0, 0, 0);
    checkOutput("rst_tms_seq", packTms(0, 6), 32'h3E);
    checkOutput("rst_tck_count", 32'(mon_tms.size()), 6);
    checkOutput("rst_rsp_time", 32'(rise_cyc - acc), 25);
    checkOutput("rst_rsp_data", last_rsp, 0);

    applyStimulus(2'd2, 6'd8, 32'hA5, 1, 32'h3C, 0, 0);
    checkOutput("dr8_tck_count", 32'(mon_tms.size()), 13);
    checkOutput("dr8_tms_seq", packTms(0, 13), 32'h1006);
    checkOutput("dr8_dev_reg", packTdi(3, 8), 32'hA5);
    checkOutput("dr8_rsp_data", last_rsp, 32'h3C);

    applyStimulus(2'd1, 6'd5, 32'h1F, 0, 0, 1, 0);
    checkOutput("ir5_tck_count", 32'(mon_tms.size()), 11);
    checkOutput("ir5_tms_seq", packTms(0, 11), 32'h606);
    checkOutput("ir5_tdi_shift", packTdi(4, 5), 32'h1F);

    applyStimulus(2'd2, 6'd12, $urandom, 0, 0, 10, 0);

    applyStimulus(2'd2, 6'd0, $urandom, 0, 0, 0, 0);
    checkOutput("dr0_tck_count", 32'(mon_tms.size()), 6);
    applyStimulus(2'd2, 6'd40, 32'h8000_0001, 0, 0, 0, 0);
    checkOutput("dr40_tck_count", 32'(mon_tms.size()), 37);
    checkOutput("dr40_tdi_shift", packTdi(3, 32), 32'h8000_0001);

    applyStimulus(2'd3, 6'd7, $urandom, 0, 0, 0, 0);
    checkOutput("idle7_tck_count", 32'(mon_tms.size()), 7);
    checkOutput("idle7_rsp_data", last_rsp, 0);

    applyStimulus(2'd2, 6'd8, $urandom, 0, 0, 0, 1);
    tick();
    applyStimulus(2'd0, 6'd0, 32'h0, 0, 0, 0, 0);
    checkOutput("post_abort_tms", packTms(0, 6), 32'h3E);
    checkOutput("post_abort_rsp", last_rsp, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 6'($urandom_range(0, 40)), $urandom,
                    0, 0, $urandom_range(0, 5), 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
# jtag_master

Host-side JTAG scan engine that drives TCK/TMS/TDI toward an on-chip or off-chip TAP and samples TDO. It accepts one command at a time (TAP reset, IR scan, DR scan, idle clocks), walks the TAP state machine with the correct TMS sequence, and shifts data MSB-first, matching the team's JTAG data registers, which shift in at bit 0 and out at bit WIDTH-1. Captured TDO bits return through a response handshake. It sits between a bus-facing debug controller and the JTAG pins/TAP.

## Interface
- DATA_WIDTH, 32, maximum scan length and width of data buses
- CLK_DIV, 2, clk cycles per TCK half-period; must be ≥ 1
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_type  in  2  0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = idle clocks
- cmd_length  in  6  bit count / idle TCK count
- cmd_data  in  DATA_WIDTH  scan data; bit [len-1] is sent first
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  DATA_WIDTH  captured TDO bits
- busy  out  1  command in progress or response pending
- jtag_tck  out  1  test clock
- jtag_tms  out  1  test mode select
- jtag_tdi  out  1  test data to TAP
- jtag_tdo  in  1  test data from TAP

## Operation
- The command is accepted on a clk edge where cmd_valid && cmd_ready are both high. cmd_type, the effective length len, and cmd_data are latched at that edge.
- len is derived from cmd_length as follows:
  - cmd_length = 0 gives len = 1.
  - cmd_length > DATA_WIDTH gives len = DATA_WIDTH.
- Every command produces exactly one response.
- States: IDLE, HEADER, SHIFT, TRAILER, RESP.
- The TMS sequence per command, starting from Run-Test/Idle:
  - Reset: TMS 1,1,1,1,1,0. 6 TCK; ends in Run-Test/Idle.
  - DR scan:
    - Header TMS 1,0 (Select-DR, Capture-DR), then 0 (enter Shift-DR).
    - len shift bits with TMS=0, except the last shift bit, which has TMS=1 (Exit1).
    - Trailer TMS 1,0 (Update, RTI).
    - Total len+5 TCK.
  - IR scan: header TMS 1,1,0,0, shift as for DR, trailer 1,0. Total len+6 TCK.
  - Idle: len TCK with TMS=0, TDI=0.
- TDI during shift: bit k of the shift (k = 0..len-1) drives cmd_data[len-1-k]. TDI is 0 outside shift.
- TDO capture: on each shift bit only, rsp_data shifts left as {rsp_data[W-2:0], tdo}. It is cleared at command accept.
  - After the command, bits [len-1:0] hold the capture, with the first-received bit at bit len-1.
  - Upper bits are 0.
  - Reset and idle commands return 0.
- Entering RESP sets rsp_valid=1. It is held, with rsp_data stable, until rsp_ready. Then the engine returns to IDLE.
- cmd_ready = (state == IDLE). busy = !cmd_ready.
- Reset mid-operation: on the next edge all outputs return to their reset values and any in-flight command and response are discarded. The TAP state is then undefined, and the controller must issue a reset command.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0, jtag_tck=0, jtag_tms=0, jtag_tdi=0.
- TCK cycle: CLK_DIV clk cycles low, then CLK_DIV clk cycles high.
- TMS/TDI change only on the clk edge that starts a low phase, and are stable through the following rising edge.
- TDO is sampled on the clk edge where jtag_tck goes 0→1.
- With accept at edge E and N total TCK cycles:
  - The first low phase starts at E+1.
  - rsp_valid rises at E+1+2·CLK_DIV·N.
  - jtag_tck is low from that edge onward.
- Between commands, jtag_tck=0, jtag_tms=0, jtag_tdi=0.
- Back-to-back commands: accept is possible on the edge after the rsp handshake (IDLE for at least 1 cycle).

## Test plan
- Reset cmd, CLK_DIV=2: TMS sampled at rising edges is 1,1,1,1,1,0; rsp_valid at E+25; rsp_data=0.
- DR scan, len=8, cmd_data=0xA5, TDO driven by a bench 8-bit register (MSB-out) preloaded 0x3C:
  - TDI bits 1,0,1,0,0,1,0,1.
  - TMS 1,0,0,0,0,0,0,0,0,0,1,1,0 (13 TCK).
  - rsp_data=0x0000003C; the bench register ends holding 0xA5.
- IR scan, len=5, cmd_data=0x1F: 11 TCK; TMS 1,1,0,0,0,0,0,0,1,1,0; TDI 1 on all five shift bits.
- Backpressure: rsp_ready held low for 10 cycles after rsp_valid → rsp_valid and rsp_data are stable, cmd_ready=0, jtag_tck stays 0.
- Length clamp: cmd_length=0 on a DR scan → 6 TCK; cmd_length=40 → 37 TCK with 32 shift bits.
- rst asserted during the 3rd shift bit of a DR scan → the next cycle has jtag_tck=0, rsp_valid=0, cmd_ready=1; a subsequent reset command completes normally.
